package_header_parser: RTL and testbench
========================================

# package_header_parser

Front-end parser for the ADC package stream inside the OFC. It consumes the 16-bit word stream from the ADC link and locates each package frame. It extracts the spill and event numbers, forwards the sample payload, and issues a one-cycle `get_package` strobe with `pkg_spillno`/`pkg_evtno`. These feed `header_checker` directly downstream. Malformed frames are dropped and flagged, so the checker only sees complete, well-framed packages.

## Interface
- `NSAMP`, default 64: payload sample words per package; legal range 1..255.
- `TRAILER`, default 16'hEEEE: required trailer word.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `live_rising` in 1: one-cycle strobe at spill start; resynchronises the parser.
- `din` in 16: ADC link word.
- `din_valid` in 1: `din` is valid this cycle.
- `pkg_spillno` out 10: spill number of the last good package.
- `pkg_evtno` out 16: event number of the last good package.
- `get_package` out 1: one-cycle strobe; a good package has completed.
- `sample_data` out 16: payload word.
- `sample_valid` out 1: `sample_data` is valid.
- `sample_idx` out 8: index of the payload word, 0..NSAMP-1.
- `format_err` out 1: one-cycle strobe; a frame was discarded.
- `pkg_count` out 16: count of good packages since the last `live_rising`.

## Operation
- Frame layout, words counted only when `din_valid`=1:
  - H0: `din[15:10]`=6'b110000 marker; `din[9:0]` carries the spill number.
  - H1: event number, 16 bits.
  - D0..D(NSAMP-1): payload.
  - T: must equal TRAILER.
- States: IDLE, EVT, DATA, TRAIL.
  - IDLE: a valid word with the marker latches the spill number into a shadow register and moves to EVT. Any other valid word is discarded silently.
  - EVT: the valid word is latched into the shadow event number; clear `sample_idx` counter; go to DATA.
  - DATA: each valid word drives `sample_valid`=1 with `sample_idx` = counter, then the counter increments. After word NSAMP-1, go to TRAIL. Payload content is never inspected; a marker pattern in DATA is plain data.
  - TRAIL, valid word equal to TRAILER: copy shadow registers to `pkg_spillno`/`pkg_evtno`, pulse `get_package`, increment `pkg_count` (wraps at 16'hFFFF→0), go to IDLE.
  - TRAIL, valid word not equal to TRAILER: pulse `format_err`, go to IDLE. Outputs and count are unchanged. The offending word is not re-examined as H0.
- Any state with `din_valid`=0: hold state and counters; no output strobes.
- `live_rising`=1 has priority over all stream processing in that cycle:
  - state → IDLE, `pkg_count` → 0, `din` ignored that cycle.
  - A partial frame is dropped without `format_err`.
  - `pkg_spillno`/`pkg_evtno` are retained.
- Reset values, all outputs: state IDLE; `pkg_spillno`=0, `pkg_evtno`=0, `pkg_count`=0, `sample_idx`=0, `sample_data`=0; all strobes 0.

## Timing
- All outputs are registered.
- `sample_valid`/`sample_data`/`sample_idx`: one cycle after the corresponding D word is accepted.
- `get_package`: one cycle after the trailer word is accepted. `pkg_spillno`/`pkg_evtno` change in that same cycle and stay stable until the next `get_package`, so `header_checker` samples them aligned with the strobe.
- `format_err`: one cycle after the bad trailer word.
- Back-to-back frames are allowed. H0 of the next frame may arrive the cycle after T; minimum frame period is NSAMP+3 valid cycles.
- `live_rising` coincident with T: the package is dropped, with no `get_package` and no `format_err`.
- `rst` asserted mid-frame: immediate return to reset values. The first frame is recognised only from the next H0 after `rst` deasserts.

## Test plan
- Clean frame, NSAMP=4, continuous valid. Stimulus: H0=16'hC005, H1=16'h0001, D=1,2,3,4, T=16'hEEEE. Required: `sample_idx` 0..3 with data 1..4; `get_package` for 1 cycle with `pkg_spillno`=5, `pkg_evtno`=1; `pkg_count`=1.
- Gapped valid. Same frame with `din_valid` toggled 1/0 each cycle. Required: identical outputs, with strobes only on accepted-word cycles+1.
- Bad trailer. T=16'hEEEF. Required: `format_err` pulse; no `get_package`; `pkg_evtno` keeps its previous value; `pkg_count` unchanged. The next clean frame parses normally.
- Junk and marker-in-payload. Stimulus: three non-marker words in IDLE, then a frame whose D1=16'hC3FF. Required: junk ignored; D1 forwarded as `sample_idx`=1; one `get_package`.
- `live_rising` mid-DATA, then a fresh frame with evtno=1. Required: no strobe for the partial frame; `pkg_count` 0→1; new frame reported correctly. Repeat with `live_rising` on the T cycle: required no strobe.
- Back-to-back: 300 frames with evtno 1..300, plus `rst` pulse mid-frame 150. Required: `get_package` for each complete frame; `pkg_count` 0 after reset. Frames before reset report `pkg_evtno` 1..149; frames after reset report `pkg_evtno` 151..300.

Source files
------------

// File: rtl/package_header_parser.sv
// Frame parser for the ADC link word stream: finds H0/H1/payload/trailer frames,
// forwards payload words and reports spill/event numbers of well-formed packages.
module package_header_parser #(
    parameter int          NSAMP   = 64,
    parameter logic [15:0] TRAILER = 16'hEEEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        live_rising,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [9:0]  pkg_spillno,
    output logic [15:0] pkg_evtno,
    output logic        get_package,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic [7:0]  sample_idx,
    output logic        format_err,
    output logic [15:0] pkg_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVT   = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [5:0] MARKER   = 6'b110000;
    localparam logic [7:0] LAST_IDX = 8'(NSAMP - 1);

    state_t      state_q;
    logic [9:0]  spill_sh_q;
    logic [15:0] evt_sh_q;
    logic [7:0]  cnt_q;
    logic [9:0]  pkg_spillno_q;
    logic [15:0] pkg_evtno_q;
    logic        get_package_q;
    logic [15:0] sample_data_q;
    logic        sample_valid_q;
    logic [7:0]  sample_idx_q;
    logic        format_err_q;
    logic [15:0] pkg_count_q;
    logic [15:0] pkg_count_d;

    // Natural 16-bit wrap from FFFF back to 0.
    assign pkg_count_d = pkg_count_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            spill_sh_q     <= '0;
            evt_sh_q       <= '0;
            cnt_q          <= '0;
            pkg_spillno_q  <= '0;
            pkg_evtno_q    <= '0;
            get_package_q  <= 1'b0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            format_err_q   <= 1'b0;
            pkg_count_q    <= '0;
        end else begin
            get_package_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            format_err_q   <= 1'b0;

            // Spill start drops any partial frame silently; last good header is kept.
            if (live_rising) begin
                state_q     <= IDLE;
                pkg_count_q <= '0;
            end else if (din_valid) begin
                unique case (state_q)
                    IDLE: begin
                        if (din[15:10] == MARKER) begin
                            spill_sh_q <= din[9:0];
                            state_q    <= EVT;
                        end
                    end
                    EVT: begin
                        evt_sh_q <= din;
                        cnt_q    <= '0;
                        state_q  <= DATA;
                    end
                    DATA: begin
                        sample_valid_q <= 1'b1;
                        sample_data_q  <= din;
                        sample_idx_q   <= cnt_q;
                        cnt_q          <= cnt_q + 8'd1;
                        if (cnt_q == LAST_IDX) begin
                            state_q <= TRAIL;
                        end
                    end
                    TRAIL: begin
                        if (din == TRAILER) begin
                            pkg_spillno_q <= spill_sh_q;
                            pkg_evtno_q   <= evt_sh_q;
                            get_package_q <= 1'b1;
                            pkg_count_q   <= pkg_count_d;
                        end else begin
                            format_err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pkg_spillno  = pkg_spillno_q;
    assign pkg_evtno    = pkg_evtno_q;
    assign get_package  = get_package_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign format_err   = format_err_q;
    assign pkg_count    = pkg_count_q;

endmodule

// File: tb/tb_package_header_parser.sv
// Directed bench for package_header_parser with NSAMP=4: clean, gapped, bad trailer,
// junk, live_rising drops, and a 300-frame back-to-back run with a mid-frame reset.
module tb_package_header_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        live_rising = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic [9:0]  pkg_spillno;
    logic [15:0] pkg_evtno;
    logic        get_package;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [7:0]  sample_idx;
    logic        format_err;
    logic [15:0] pkg_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed-event record, filled at negedges
    int          gp_cnt   = 0;
    int          fe_cnt   = 0;
    int          samp_cnt = 0;
    logic [15:0] samp [0:3];
    logic [15:0] evq [$];

    package_header_parser #(.NSAMP(4), .TRAILER(16'hEEEE)) dut (
        .clk(clk), .rst(rst), .live_rising(live_rising), .din(din), .din_valid(din_valid),
        .pkg_spillno(pkg_spillno), .pkg_evtno(pkg_evtno), .get_package(get_package),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_idx(sample_idx),
        .format_err(format_err), .pkg_count(pkg_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (get_package) begin
            gp_cnt = gp_cnt + 1;
            evq.push_back(pkg_evtno);
        end
        if (format_err) fe_cnt = fe_cnt + 1;
        if (sample_valid) begin
            samp_cnt = samp_cnt + 1;
            if (sample_idx < 8'd4) samp[sample_idx[1:0]] = sample_data;
        end
    end

    task automatic put(input logic [15:0] d, input logic v, input logic lr);
        @(negedge clk);
        din = d;
        din_valid = v;
        live_rising = lr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic clr();
        #1;
        gp_cnt = 0;
        fe_cnt = 0;
        samp_cnt = 0;
        evq.delete();
        for (int i = 0; i < 4; i++) samp[i] = 16'hDEAD;
    endtask

    task automatic frame(input logic [9:0] sp, input logic [15:0] ev, input logic [15:0] dbase,
                         input logic [15:0] d1, input logic [15:0] tr, input bit gap, input bit lr_t);
        logic [15:0] w [0:6];
        w[0] = {6'b110000, sp};
        w[1] = ev;
        w[2] = dbase;
        w[3] = d1;
        w[4] = dbase + 16'd2;
        w[5] = dbase + 16'd3;
        w[6] = tr;
        for (int i = 0; i < 7; i++) begin
            put(w[i], 1'b1, (i == 6) && lr_t);
            if (gap) put(16'hC0AA, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b1;
        din = 16'hC00F;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({pkg_spillno, pkg_evtno, pkg_count, sample_idx, sample_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: spill=%0h evt=%0h cnt=%0h idx=%0h data=%0h required all 0",
                     pkg_spillno, pkg_evtno, pkg_count, sample_idx, sample_data);
        end
        n_checks++;
        if ({get_package, sample_valid, format_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: gp=%b sv=%b fe=%b required 000", get_package, sample_valid, format_err);
        end
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        idle(2);
        clr();
    endtask

    task automatic test_clean();
        clr();
        frame(10'd5, 16'h0001, 16'd1, 16'd2, 16'hEEEE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_checks++;
        if (get_package !== 1'b1 || pkg_spillno !== 10'd5 || pkg_evtno !== 16'h0001) begin
            n_fail++;
            $display("FAIL clean_strobe_timing: gp=%b spill=%0d evt=%0d required gp=1 spill=5 evt=1",
                     get_package, pkg_spillno, pkg_evtno);
        end
        idle(3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (samp[i] !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL clean_sample[%0d]: got %0h required %0h", i, samp[i], i + 1);
            end
        end
        n_checks++;
        if (samp_cnt != 4 || gp_cnt != 1 || fe_cnt != 0 || pkg_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clean_counts: samples=%0d gp=%0d fe=%0d pkg_count=%0d required 4 1 0 1",
                     samp_cnt, gp_cnt, fe_cnt, pkg_count);
        end
    endtask

    task automatic test_gapped();
        clr();
        frame(10'd5, 16'h0001, 16'd1, 16'd2, 16'hEEEE, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (samp[i] !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL gapped_sample[%0d]: got %0h required %0h", i, samp[i], i + 1);
            end
        end
        n_checks++;
        if (samp_cnt != 4 || gp_cnt != 1 || fe_cnt != 0 || pkg_count !== 16'd2 ||
            pkg_spillno !== 10'd5 || pkg_evtno !== 16'd1) begin
            n_fail++;
            $display("FAIL gapped_counts: samples=%0d gp=%0d fe=%0d cnt=%0d spill=%0d evt=%0d required 4 1 0 2 5 1",
                     samp_cnt, gp_cnt, fe_cnt, pkg_count, pkg_spillno, pkg_evtno);
        end
    endtask

    task automatic test_bad_trailer();
        clr();
        frame(10'd7, 16'h0009, 16'd1, 16'd2, 16'hEEEF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_checks++;
        if (format_err !== 1'b1 || get_package !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_trailer_strobe: fe=%b gp=%b required fe=1 gp=0", format_err, get_package);
        end
        idle(3);
        n_checks++;
        if (fe_cnt != 1 || gp_cnt != 0 || pkg_evtno !== 16'd1 || pkg_spillno !== 10'd5 || pkg_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bad_trailer_state: fe=%0d gp=%0d evt=%0d spill=%0d cnt=%0d required 1 0 1 5 2",
                     fe_cnt, gp_cnt, pkg_evtno, pkg_spillno, pkg_count);
        end
        clr();
        frame(10'd8, 16'h000A, 16'd1, 16'd2, 16'hEEEE, 1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (gp_cnt != 1 || fe_cnt != 0 || pkg_evtno !== 16'h000A || pkg_spillno !== 10'd8 || pkg_count !== 16'd3) begin
            n_fail++;
            $display("FAIL after_bad_frame: gp=%0d fe=%0d evt=%0h spill=%0d cnt=%0d required 1 0 a 8 3",
                     gp_cnt, fe_cnt, pkg_evtno, pkg_spillno, pkg_count);
        end
    endtask

    task automatic test_junk();
        clr();
        put(16'h1234, 1'b1, 1'b0);
        put(16'hC400, 1'b1, 1'b0);
        put(16'hEEEE, 1'b1, 1'b0);
        frame(10'd3, 16'h0055, 16'h0010, 16'hC3FF, 16'hEEEE, 1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (samp[1] !== 16'hC3FF || samp[0] !== 16'h0010 || samp[3] !== 16'h0013) begin
            n_fail++;
            $display("FAIL junk_payload: d0=%0h d1=%0h d3=%0h required 10 c3ff 13", samp[0], samp[1], samp[3]);
        end
        n_checks++;
        if (gp_cnt != 1 || fe_cnt != 0 || samp_cnt != 4 || pkg_evtno !== 16'h0055 ||
            pkg_spillno !== 10'd3 || pkg_count !== 16'd4) begin
            n_fail++;
            $display("FAIL junk_counts: gp=%0d fe=%0d samples=%0d evt=%0h spill=%0d cnt=%0d required 1 0 4 55 3 4",
                     gp_cnt, fe_cnt, samp_cnt, pkg_evtno, pkg_spillno, pkg_count);
        end
    endtask

    task automatic test_live_rising();
        clr();
        put(16'hC001, 1'b1, 1'b0);
        put(16'h0077, 1'b1, 1'b0);
        put(16'h0001, 1'b1, 1'b0);
        put(16'h0002, 1'b1, 1'b0);
        put(16'h0003, 1'b1, 1'b1);
        put(16'h0000, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (pkg_count !== 16'd0 || pkg_evtno !== 16'h0055) begin
            n_fail++;
            $display("FAIL live_rising_clear: cnt=%0d evt=%0h required 0 55", pkg_count, pkg_evtno);
        end
        frame(10'd2, 16'h0001, 16'd1, 16'd2, 16'hEEEE, 1'b0, 1'b0);
        idle(3);
        n_checks++;
        if (gp_cnt != 1 || fe_cnt != 0 || pkg_count !== 16'd1 || pkg_evtno !== 16'd1 || pkg_spillno !== 10'd2) begin
            n_fail++;
            $display("FAIL live_rising_fresh: gp=%0d fe=%0d cnt=%0d evt=%0d spill=%0d required 1 0 1 1 2",
                     gp_cnt, fe_cnt, pkg_count, pkg_evtno, pkg_spillno);
        end
        clr();
        frame(10'd4, 16'h0002, 16'd1, 16'd2, 16'hEEEE, 1'b0, 1'b1);
        idle(3);
        n_checks++;
        if (gp_cnt != 0 || fe_cnt != 0 || pkg_count !== 16'd0 || pkg_evtno !== 16'd1 || pkg_spillno !== 10'd2) begin
            n_fail++;
            $display("FAIL live_rising_on_trailer: gp=%0d fe=%0d cnt=%0d evt=%0d spill=%0d required 0 0 0 1 2",
                     gp_cnt, fe_cnt, pkg_count, pkg_evtno, pkg_spillno);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ev;
        clr();
        for (int i = 1; i <= 300; i++) begin
            ev = 16'(i);
            if (i == 150) begin
                put({6'b110000, 10'd150}, 1'b1, 1'b0);
                put(ev, 1'b1, 1'b0);
                put(16'(i * 4), 1'b1, 1'b0);
                #1;
                n_checks++;
                if (pkg_count !== 16'd149 || pkg_evtno !== 16'd149) begin
                    n_fail++;
                    $display("FAIL b2b_before_reset: cnt=%0d evt=%0d required 149 149", pkg_count, pkg_evtno);
                end
                @(negedge clk);
                rst = 1'b1;
                din_valid = 1'b0;
                #1;
                n_checks++;
                if (pkg_count !== 16'd0 || pkg_evtno !== 16'd0 || pkg_spillno !== 10'd0) begin
                    n_fail++;
                    $display("FAIL b2b_async_reset: cnt=%0d evt=%0d spill=%0d required 0 0 0",
                             pkg_count, pkg_evtno, pkg_spillno);
                end
                @(negedge clk);
                rst = 1'b0;
                put(16'(i * 4 + 1), 1'b1, 1'b0);
                put(16'(i * 4 + 2), 1'b1, 1'b0);
                put(16'(i * 4 + 3), 1'b1, 1'b0);
                put(16'hEEEE, 1'b1, 1'b0);
            end else begin
                frame(ev[9:0], ev, 16'(i * 4), 16'(i * 4 + 1), 16'hEEEE, 1'b0, 1'b0);
            end
        end
        idle(3);
        n_checks++;
        if (gp_cnt != 299 || fe_cnt != 0 || pkg_count !== 16'd150 || pkg_evtno !== 16'd300) begin
            n_fail++;
            $display("FAIL b2b_totals: gp=%0d fe=%0d cnt=%0d evt=%0d required 299 0 150 300",
                     gp_cnt, fe_cnt, pkg_count, pkg_evtno);
        end
        for (int k = 0; k < evq.size() && k < 299; k++) begin
            ev = (k < 149) ? 16'(k + 1) : 16'(k + 2);
            n_checks++;
            if (evq[k] !== ev) begin
                n_fail++;
                $display("FAIL b2b_evtno[%0d]: got %0d required %0d", k, evq[k], ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_gapped();
        test_bad_trailer();
        test_junk();
        test_live_rising();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
